instr_exec_sequencer: RTL



---
 rtl/instr_register_pkg.sv | 63 ++++++
 rtl/instr_pow_unit.sv | 91 +++++++++
 rtl/instr_exec_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the 32-entry instruction register and the execution
// sequencer that walks it.
//   opcode_t      : 4-bit opcode; encodings 9..15 are undefined (faulted)
//   operand_t     : 32-bit signed operand
//   rezultat_t    : 62-bit signed result written back to the register
//   address_t     : 5-bit entry index (32 entries)
//   instruction_t : {opcode, op_a, op_b}
//   exec_state_t  : sequencer FSM states
// Helper functions sign-extend operand-sized values into a result word.
// -----------------------------------------------------------------------------
package instr_register_pkg;

  localparam int RES_W  = 62;
  localparam int OP_W   = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef logic signed [OP_W-1:0]   operand_t;
  typedef logic signed [RES_W-1:0]  rezultat_t;
  typedef logic        [ADDR_W-1:0] address_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_POW_LOOP = 3'd3,
    S_WB       = 3'd4,
    S_DONE     = 3'd5
  } exec_state_t;

  localparam rezultat_t RES_ZERO = {RES_W{1'b0}};
  localparam rezultat_t RES_ONE  = {{(RES_W-1){1'b0}}, 1'b1};

  // Sign-extend a 32-bit operand to the result width.
  function automatic rezultat_t sext_op(input operand_t v);
    return {{(RES_W-OP_W){v[OP_W-1]}}, v};
  endfunction

  // Sign-extend a 33-bit intermediate (add/sub/div/mod) to the result width.
  function automatic rezultat_t sext33(input logic signed [OP_W:0] v);
    return {{(RES_W-OP_W-1){v[OP_W]}}, v};
  endfunction

endpackage

// File: rtl/instr_pow_unit.sv
// -----------------------------------------------------------------------------
// instr_pow_unit
// Square-and-multiply datapath: one exponent bit per clock. All products are
// kept at the 62-bit result width (wrap-around truncation).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : abandon an evaluation in flight
//   start        : load acc=1, base=base_in, exp=exp_in (exp_in > 0)
//   base_in      : signed base operand
//   exp_in       : exponent, positive when start is asserted
//   done         : high in the cycle performing the final iteration
//   result       : accumulator value after the current iteration
// done/result are combinational from the internal registers; the caller
// captures result into its own register when done is high.
// -----------------------------------------------------------------------------
module instr_pow_unit
  import instr_register_pkg::*;
#(
  parameter int POW_MAX_ITER = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      start,
  input  operand_t  base_in,
  input  operand_t  exp_in,
  output logic      done,
  output rezultat_t result
);

  localparam int ITER_W = $clog2(POW_MAX_ITER) + 1;

  logic              running;
  rezultat_t         acc;
  rezultat_t         base;
  logic [OP_W-1:0]   exp_q;
  logic [ITER_W-1:0] iter;

  rezultat_t         acc_next;
  rezultat_t         base_next;
  logic [OP_W-1:0]   exp_next;
  logic              last_iter;

  // Next-iteration values; the iteration cap guards against runaway exponents
  always_comb begin
    if (exp_q[0]) begin
      acc_next = acc * base;
    end else begin
      acc_next = acc;
    end
    base_next = base * base;
    exp_next  = exp_q >> 1;
    last_iter = (exp_next == {OP_W{1'b0}}) ||
                (iter == ITER_W'(POW_MAX_ITER - 1));
  end

  assign done   = running & last_iter;
  assign result = acc_next;

  // Iteration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      acc     <= RES_ZERO;
      base    <= RES_ZERO;
      exp_q   <= {OP_W{1'b0}};
      iter    <= {ITER_W{1'b0}};
    end else if (clear) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      acc     <= RES_ONE;
      base    <= sext_op(base_in);
      exp_q   <= exp_in;
      iter    <= {ITER_W{1'b0}};
    end else if (running) begin
      acc     <= acc_next;
      base    <= base_next;
      exp_q   <= exp_next;
      iter    <= iter + ITER_W'(1);
      if (last_iter) begin
        running <= 1'b0;
      end else begin
        running <= 1'b1;
      end
    end else begin
      running <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// -----------------------------------------------------------------------------
// instr_exec_sequencer
// Walks an inclusive address window of the 32-entry instruction register
// (wrapping 31->0), fetches each instruction, evaluates it and writes the
// result back to the same entry. One instruction at a time: FETCH, EXEC, WB
// (3 cycles), POW adds one POW_LOOP cycle per exponent bit.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start                  : begin a sweep (accepted only in IDLE)
//   first_addr, last_addr  : window bounds, latched on an accepted start
//   halt                   : abort the sweep; next state IDLE, no done
//   rd_addr / rd_instr     : read port of the instruction register
//   wb_en/wb_addr/wb_result: one-cycle write-back to the register
//   busy                   : high in every state except IDLE
//   done                   : one-cycle pulse at sweep completion
//   err                    : faulted instruction, coincident with wb_en
//   err_count              : (INSTR_EXEC_ERR_CNT_EN only) saturating count of
//                            err pulses, cleared on reset and accepted start
// Optional feature macro: INSTR_EXEC_ERR_CNT_EN.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module instr_exec_sequencer
  import instr_register_pkg::*;
#(
  parameter int POW_MAX_ITER = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     first_addr,
  input  address_t     last_addr,
  input  logic         halt,
  output address_t     rd_addr,
  input  instruction_t rd_instr,
  output logic         wb_en,
  output address_t     wb_addr,
  output rezultat_t    wb_result,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef INSTR_EXEC_ERR_CNT_EN
  ,
  output logic [15:0]  err_count
`endif
);

  exec_state_t  state;
  address_t     cur;
  address_t     last_a;
  instruction_t instr_q;

  logic signed [OP_W:0] a_ext;
  logic signed [OP_W:0] b_ext;
  logic                 b_zero;
  rezultat_t            exec_res;
  logic                 exec_err;
  logic                 exec_loop;

  logic                 pow_start;
  logic                 pow_done;
  rezultat_t            pow_result;

  // Single-cycle opcode evaluation of the fetched instruction
  always_comb begin
    a_ext     = {instr_q.op_a[OP_W-1], instr_q.op_a};
    b_ext     = {instr_q.op_b[OP_W-1], instr_q.op_b};
    b_zero    = (instr_q.op_b == 32'sd0);
    exec_res  = RES_ZERO;
    exec_err  = 1'b0;
    exec_loop = 1'b0;
    case (instr_q.opcode)
      ZERO:  exec_res = RES_ZERO;
      PASSA: exec_res = sext_op(instr_q.op_a);
      PASSB: exec_res = sext_op(instr_q.op_b);
      ADD:   exec_res = sext33(a_ext + b_ext);
      SUB:   exec_res = sext33(a_ext - b_ext);
      // low 62 bits of the signed product equal the product of the
      // sign-extended operands taken modulo 2^62
      MULT:  exec_res = sext_op(instr_q.op_a) * sext_op(instr_q.op_b);
      // 33-bit division keeps -2^31 / -1 exact
      DIV: begin
        if (b_zero) begin
          exec_err = 1'b1;
        end else begin
          exec_res = sext33(a_ext / b_ext);
        end
      end
      MOD: begin
        if (b_zero) begin
          exec_err = 1'b1;
        end else begin
          exec_res = sext33(a_ext % b_ext);
        end
      end
      POW: begin
        if (instr_q.op_b[OP_W-1]) begin
          exec_err = 1'b1;
        end else if (b_zero) begin
          exec_res = RES_ONE;
        end else begin
          exec_loop = 1'b1;
        end
      end
      default: exec_err = 1'b1;
    endcase
  end

  assign pow_start = (state == S_EXEC) && exec_loop && !halt;

  instr_pow_unit #(
    .POW_MAX_ITER (POW_MAX_ITER)
  ) u_pow (
    .clk     (clk),
    .reset   (reset),
    .clear   (halt),
    .start   (pow_start),
    .base_in (instr_q.op_a),
    .exp_in  (instr_q.op_b),
    .done    (pow_done),
    .result  (pow_result)
  );

  // Sequencer FSM with registered outputs; reset > halt > start
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= 5'd0;
      last_a    <= 5'd0;
      instr_q   <= '{opcode: ZERO, op_a: 32'sd0, op_b: 32'sd0};
      rd_addr   <= 5'd0;
      wb_en     <= 1'b0;
      wb_addr   <= 5'd0;
      wb_result <= RES_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      if (halt) begin
        // a write already on the bus this cycle completes; nothing follows
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cur     <= first_addr;
              last_a  <= last_addr;
              rd_addr <= first_addr;
              busy    <= 1'b1;
              state   <= S_FETCH;
            end else begin
              state <= S_IDLE;
            end
          end
          S_FETCH: begin
            instr_q <= rd_instr;
            state   <= S_EXEC;
          end
          S_EXEC: begin
            if (exec_loop) begin
              state <= S_POW_LOOP;
            end else begin
              wb_en     <= 1'b1;
              wb_addr   <= cur;
              wb_result <= exec_res;
              err       <= exec_err;
              state     <= S_WB;
            end
          end
          S_POW_LOOP: begin
            if (pow_done) begin
              wb_en     <= 1'b1;
              wb_addr   <= cur;
              wb_result <= pow_result;
              state     <= S_WB;
            end else begin
              state <= S_POW_LOOP;
            end
          end
          S_WB: begin
            if (cur == last_a) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cur     <= cur + 5'd1;
              rd_addr <= cur + 5'd1;
              state   <= S_FETCH;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef INSTR_EXEC_ERR_CNT_EN
  // Saturating count of faulted instructions, counted as each err pulse ends
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 16'd0;
    end else if ((state == S_IDLE) && start && !halt) begin
      err_count <= 16'd0;
    end else if (err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule
